square_root_seq: RTL and testbench
==================================

Name: square_root_seq

Overview:
Multi-cycle, handshaked integer square root. It is the parametrised successor to the team's single-shot combinational root. It resolves ITER_PER_CYCLE root bits per clock using non-restoring add/subtract iterations. It returns the floor root, the remainder, and an optional round-to-nearest root. It sits in the LiDAR point-filter datapath, where it converts squared distances to distances with valid/ready flow control toward downstream filters.

Parameters:
N, 32, input width in bits; even, >= 4
ITER_PER_CYCLE, 1, root bits resolved per clock; must divide N/2 exactly (1, 2, 4, ... up to N/2)
ROUND, 0, 1 = root_out is rounded to nearest; 0 = floor root

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  num_in is valid
in_ready  out  1  block can accept num_in this cycle
num_in  in  N  unsigned radicand
out_valid  out  1  root_out and rem_out are valid
out_ready  in  1  downstream accepts the result
root_out  out  N/2  root: floor, or rounded if ROUND=1
rem_out  out  N/2+1  num_in - floor_root^2; always the floor remainder
busy  out  1  high while iterating

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- FSM states: IDLE, BUSY, DONE.
- Reset (sampled high on a rising edge) forces IDLE and the following values:
  - in_ready=1, out_valid=0, busy=0
  - root_out=0, rem_out=0
  - internal q, r, a and iteration counter = 0
- Reset mid-BUSY or mid-DONE aborts the operation. No result is produced.

Handshake:
- Input transfer happens when in_valid && in_ready on a rising edge.
- Output transfer happens when out_valid && out_ready on a rising edge.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- This allows back-to-back operation: in the same cycle a result drains and a new input is captured.

Transitions:
- IDLE → BUSY on an input transfer. The edge latches a = num_in and clears q, r and the counter.
- BUSY: each clock performs ITER_PER_CYCLE iterations. Per iteration:
  - right = {q, r[MSB], 1}
  - left = {r[N/2-1:0], a[N-1:N-2]}
  - a <<= 2
  - r = r negative ? left + right : left - right
  - q = {q, ~r[MSB]}
  - The remainder is N/2+2 bits wide, two's complement.
- BUSY → DONE after exactly N/(2*ITER_PER_CYCLE) BUSY clocks.
  - On that edge: if final r is negative, apply the restoring correction r = r + {q, 1}.
  - On the same edge, root_out and rem_out are registered and out_valid is set.
- DONE holds root_out, rem_out and out_valid stable until an output transfer.
  - DONE → IDLE on an output transfer with no new input.
  - DONE → BUSY on an output transfer with a simultaneous input transfer.
  - out_valid must not drop without out_ready.

Timing and throughput:
- Latency from the input-transfer edge to out_valid high is N/(2*ITER_PER_CYCLE) clocks.
- Throughput, with out_ready held high, is one result per N/(2*ITER_PER_CYCLE)+1 clocks.

Rounding (ROUND=1):
- root_out = floor_root + 1 if rem > floor_root, else floor_root.
- Ties cannot occur for integers.
- Saturate at 2^(N/2)-1 if the increment would overflow.
- rem_out stays the floor remainder.

Other rules:
- busy = (state==BUSY).
- in_valid during BUSY is ignored. in_ready=0, so the upstream holds its data.
- X on num_in when in_valid=0 must not propagate into any state.

Test Plan:
- N=32, K=1, ROUND=0: num_in=0, then 1, then 1000000 → root 0/1/1000, rem 0/0/0; out_valid rises exactly 16 clocks after each accept.
- N=32: num_in=0xFFFFFFFF → root 65535, rem 131070. With ROUND=1, root saturates at 65535 and rem is still 131070.
- ROUND=1, N=32: num_in=15 → root 4, rem 6. num_in=12 → root 3, rem 3 (3 is not > 3). num_in=13 → root 4.
- Backpressure: hold out_ready=0 for 10 clocks in DONE → outputs stable, in_ready=0. Then assert out_ready with in_valid=1 and num_in=81 → result accepted and new op captured on the same edge; root 9, rem 0 follows 16 clocks later.
- Reset mid-op: assert reset 5 clocks into BUSY → next cycle state IDLE, out_valid=0, in_ready=1, outputs 0; no stale result ever appears.
- Parameter sweep: N=16 with K in {1,2,4,8}, randomized against a floor(sqrt) reference model. Check the root^2 <= num < (root+1)^2 invariant and rem = num - root^2. Check latency 8/4/2/1 clocks.

Source files
------------

// File: rtl/square_root_seq_if.sv
// Handshake bundle for square_root_seq.
//   in_valid / in_ready / num_in             : radicand request channel
//   out_valid / out_ready / root_out / rem_out : result channel
//   busy                                     : status, high while iterating
// master = upstream/downstream side driving requests and consuming results,
// slave  = the square-root engine.
interface square_root_seq_if #(
   parameter int N = 32
);
   logic           in_valid;
   logic           in_ready;
   logic [N-1:0]   num_in;
   logic           out_valid;
   logic           out_ready;
   logic [N/2-1:0] root_out;
   logic [N/2:0]   rem_out;
   logic           busy;

   modport master (
      output in_valid, num_in, out_ready,
      input  in_ready, out_valid, root_out, rem_out, busy
   );

   modport slave (
      input  in_valid, num_in, out_ready,
      output in_ready, out_valid, root_out, rem_out, busy
   );
endinterface

// File: rtl/square_root_seq.sv
// Multi-cycle non-restoring integer square root with valid/ready handshake.
// Resolves ITER_PER_CYCLE root bits per clock; returns floor (or rounded)
// root and the floor remainder.
//   clock : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : square_root_seq_if slave port (request, result, busy)
//
// state | meaning
// IDLE  | waiting for a radicand, in_ready high
// BUSY  | iterating, ITER_PER_CYCLE root bits per clock
// DONE  | result held on root_out/rem_out until out_ready
module square_root_seq #(
   parameter int N              = 32,
   parameter int ITER_PER_CYCLE = 1,
   parameter int ROUND          = 0
) (
   input logic               clock,
   input logic               reset,
   square_root_seq_if.slave  bus
);
   localparam int H     = N / 2;
   localparam int STEPS = H / ITER_PER_CYCLE;
   localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t        state;
   logic [N-1:0]  a, a_n;
   logic [H-1:0]  q, q_n;
   logic [H+1:0]  r, r_n, r_fix, left_v, right_v;
   logic [CW-1:0] cnt;
   logic [H:0]    rem_c;
   logic [H-1:0]  root_c;
   logic          in_xfer;

   assign bus.in_ready = (state == IDLE) || ((state == DONE) && bus.out_ready);
   assign bus.busy     = (state == BUSY);
   assign in_xfer      = bus.in_valid && bus.in_ready;

   // One clock's worth of non-restoring iterations; r is two's complement.
   always_comb begin
      a_n     = a;
      q_n     = q;
      r_n     = r;
      left_v  = '0;
      right_v = '0;
      for (int i = 0; i < ITER_PER_CYCLE; i++) begin
         right_v = {q_n, r_n[H+1], 1'b1};
         left_v  = {r_n[H-1:0], a_n[N-1:N-2]};
         a_n     = a_n << 2;
         r_n     = r_n[H+1] ? left_v + right_v : left_v - right_v;
         q_n     = {q_n[H-2:0], ~r_n[H+1]};
      end
   end

   // Final restoring step and optional round-to-nearest (saturating).
   always_comb begin
      r_fix  = r_n[H+1] ? r_n + {1'b0, q_n, 1'b1} : r_n;
      rem_c  = r_fix[H:0];
      root_c = q_n;
      if ((ROUND != 0) && (rem_c > {1'b0, q_n}) && !(&q_n))
         root_c = q_n + 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         a             <= '0;
         q             <= '0;
         r             <= '0;
         cnt           <= '0;
         bus.out_valid <= 1'b0;
         bus.root_out  <= '0;
         bus.rem_out   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_xfer) begin
                  a     <= bus.num_in;
                  q     <= '0;
                  r     <= '0;
                  cnt   <= '0;
                  state <= BUSY;
               end
            end
            BUSY: begin
               a <= a_n;
               q <= q_n;
               if (cnt == LAST) begin
                  r             <= r_fix;
                  bus.root_out  <= root_c;
                  bus.rem_out   <= rem_c;
                  bus.out_valid <= 1'b1;
                  state         <= DONE;
               end else begin
                  r   <= r_n;
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  if (in_xfer) begin
                     a     <= bus.num_in;
                     q     <= '0;
                     r     <= '0;
                     cnt   <= '0;
                     state <= BUSY;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_square_root_seq.sv
// Testbench for square_root_seq: N=32 floor and rounded instances share one
// stimulus; four N=16 instances (1/2/4/8 bits per clock) share another.
module tb_square_root_seq;
   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        rst;
   logic        iv32, ordy32;
   logic [31:0] num32;
   logic        iv16, ordy16;
   logic [15:0] num16;
   int          nvec = 0;
   int          nerr = 0;

   square_root_seq_if #(.N(32)) bus_f ();
   square_root_seq_if #(.N(32)) bus_r ();

   assign bus_f.in_valid  = iv32;
   assign bus_f.num_in    = num32;
   assign bus_f.out_ready = ordy32;
   assign bus_r.in_valid  = iv32;
   assign bus_r.num_in    = num32;
   assign bus_r.out_ready = ordy32;

   square_root_seq #(.N(32), .ITER_PER_CYCLE(1), .ROUND(0)) dut_f (
      .clock(clock), .reset(rst), .bus(bus_f));
   square_root_seq #(.N(32), .ITER_PER_CYCLE(1), .ROUND(1)) dut_r (
      .clock(clock), .reset(rst), .bus(bus_r));

   logic [3:0] ov16, ir16, bz16;
   logic [7:0] root16 [4];
   logic [8:0] rem16  [4];

   for (genvar g = 0; g < 4; g++) begin : g16
      square_root_seq_if #(.N(16)) ifc ();
      assign ifc.in_valid  = iv16;
      assign ifc.num_in    = num16;
      assign ifc.out_ready = ordy16;
      assign ov16[g]   = ifc.out_valid;
      assign ir16[g]   = ifc.in_ready;
      assign bz16[g]   = ifc.busy;
      assign root16[g] = ifc.root_out;
      assign rem16[g]  = ifc.rem_out;
      square_root_seq #(.N(16), .ITER_PER_CYCLE(1 << g), .ROUND(0)) dut (
         .clock(clock), .reset(rst), .bus(ifc));
   end

   // Reference: floor sqrt by binary search on plain arithmetic.
   function automatic longint unsigned isqrt(input longint unsigned x);
      longint unsigned lo, hi, mid;
      lo = 0;
      hi = 65536;
      while (lo < hi) begin
         mid = (lo + hi + 1) / 2;
         if (mid * mid <= x) lo = mid;
         else hi = mid - 1;
      end
      return lo;
   endfunction

   function automatic longint unsigned rnd_root(input longint unsigned x, input int h);
      longint unsigned f;
      f = isqrt(x);
      if ((x - f * f > f) && (f < (64'd1 << h) - 1)) return f + 1;
      return f;
   endfunction

   task automatic do32(input logic [31:0] x, output int lat);
      iv32  = 1'b1;
      num32 = x;
      @(posedge clock); #1;
      num32 = $urandom;     // junk offered while busy must be ignored
      lat = 0;
      while (!bus_f.out_valid && lat < 100) begin
         @(posedge clock); #1;
         lat++;
      end
      iv32  = 1'b0;
      num32 = 'x;
   endtask

   task automatic drain32();
      iv32   = 1'b0;
      ordy32 = 1'b1;
      @(posedge clock); #1;
      ordy32 = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; iv32 = 1'b0; ordy32 = 1'b0; num32 = '0;
      iv16 = 1'b0; ordy16 = 1'b0; num16 = '0;
      repeat (3) @(posedge clock);
      #1 rst = 1'b0;
      nvec++;
      if ({bus_f.in_ready, bus_f.out_valid, bus_f.busy} !== 3'b100) begin
         nerr++; $display("FAIL reset_flags_f got %b expected 100", {bus_f.in_ready, bus_f.out_valid, bus_f.busy});
      end
      nvec++;
      if ({bus_r.root_out, bus_r.rem_out, bus_f.root_out, bus_f.rem_out} !== '0) begin
         nerr++; $display("FAIL reset_outputs got root %0d rem %0d expected 0", bus_f.root_out, bus_f.rem_out);
      end
      nvec++;
      if ({ir16, ov16, bz16} !== 12'hF00) begin
         nerr++; $display("FAIL reset_flags_16 got %h expected f00", {ir16, ov16, bz16});
      end
   endtask

   task automatic test_basic32();
      logic [31:0] vals [3] = '{32'd0, 32'd1, 32'd1000000};
      int          eroot[3] = '{0, 1, 1000};
      int lat;
      for (int i = 0; i < 3; i++) begin
         do32(vals[i], lat);
         nvec++;
         if (lat !== 16) begin
            nerr++; $display("FAIL basic_latency x=%0d got %0d expected 16", vals[i], lat);
         end
         nvec++;
         if (bus_f.root_out !== 16'(eroot[i]) || bus_f.rem_out !== 17'd0) begin
            nerr++; $display("FAIL basic_result x=%0d got root %0d rem %0d expected %0d 0", vals[i], bus_f.root_out, bus_f.rem_out, eroot[i]);
         end
         nvec++;
         if (bus_r.root_out !== 16'(rnd_root(vals[i], 16))) begin
            nerr++; $display("FAIL basic_round x=%0d got %0d expected %0d", vals[i], bus_r.root_out, rnd_root(vals[i], 16));
         end
         drain32();
         nvec++;
         if ({bus_f.out_valid, bus_f.in_ready} !== 2'b01) begin
            nerr++; $display("FAIL basic_drain got %b expected 01", {bus_f.out_valid, bus_f.in_ready});
         end
      end
   endtask

   task automatic test_max32();
      int lat;
      do32(32'hFFFF_FFFF, lat);
      nvec++;
      if (bus_f.root_out !== 16'd65535 || bus_f.rem_out !== 17'd131070) begin
         nerr++; $display("FAIL max_floor got root %0d rem %0d expected 65535 131070", bus_f.root_out, bus_f.rem_out);
      end
      nvec++;
      if (bus_r.root_out !== 16'd65535 || bus_r.rem_out !== 17'd131070) begin
         nerr++; $display("FAIL max_round got root %0d rem %0d expected 65535 131070", bus_r.root_out, bus_r.rem_out);
      end
      drain32();
   endtask

   task automatic test_round32();
      logic [31:0] vals [3] = '{32'd15, 32'd12, 32'd13};
      int          er   [3] = '{4, 3, 4};
      int          erem [3] = '{6, 3, 4};
      int lat;
      for (int i = 0; i < 3; i++) begin
         do32(vals[i], lat);
         nvec++;
         if (bus_r.root_out !== 16'(er[i]) || bus_r.rem_out !== 17'(erem[i])) begin
            nerr++; $display("FAIL round x=%0d got root %0d rem %0d expected %0d %0d", vals[i], bus_r.root_out, bus_r.rem_out, er[i], erem[i]);
         end
         nvec++;
         if (bus_f.root_out !== 16'd3) begin
            nerr++; $display("FAIL round_floor x=%0d got %0d expected 3", vals[i], bus_f.root_out);
         end
         drain32();
      end
   endtask

   task automatic test_backpressure();
      int lat;
      int bad = 0;
      do32(32'd100, lat);
      for (int i = 0; i < 10; i++) begin
         @(posedge clock); #1;
         if ({bus_f.out_valid, bus_f.in_ready} !== 2'b10 || bus_f.root_out !== 16'd10 || bus_f.rem_out !== 17'd0)
            bad++;
      end
      nvec++;
      if (bad != 0) begin
         nerr++; $display("FAIL bp_hold got %0d unstable cycles expected 0", bad);
      end
      ordy32 = 1'b1; iv32 = 1'b1; num32 = 32'd81;
      #1;
      nvec++;
      if (bus_f.in_ready !== 1'b1) begin
         nerr++; $display("FAIL bp_in_ready got %b expected 1", bus_f.in_ready);
      end
      @(posedge clock); #1;
      ordy32 = 1'b0; iv32 = 1'b0; num32 = 'x;
      nvec++;
      if ({bus_f.busy, bus_f.out_valid} !== 2'b10) begin
         nerr++; $display("FAIL bp_capture got %b expected 10", {bus_f.busy, bus_f.out_valid});
      end
      lat = 0;
      while (!bus_f.out_valid && lat < 100) begin
         @(posedge clock); #1;
         lat++;
      end
      nvec++;
      if (lat !== 16 || bus_f.root_out !== 16'd9 || bus_f.rem_out !== 17'd0) begin
         nerr++; $display("FAIL bp_result got lat %0d root %0d rem %0d expected 16 9 0", lat, bus_f.root_out, bus_f.rem_out);
      end
      drain32();
   endtask

   task automatic test_reset_midop();
      int stale = 0;
      iv32 = 1'b1; num32 = 32'd12345;
      @(posedge clock); #1;
      iv32 = 1'b0;
      repeat (5) @(posedge clock);
      #1;
      nvec++;
      if (bus_f.busy !== 1'b1) begin
         nerr++; $display("FAIL midop_busy got %b expected 1", bus_f.busy);
      end
      rst = 1'b1;
      @(posedge clock); #1;
      rst = 1'b0;
      nvec++;
      if ({bus_f.in_ready, bus_f.out_valid, bus_f.busy} !== 3'b100 || bus_f.root_out !== 16'd0 || bus_f.rem_out !== 17'd0) begin
         nerr++; $display("FAIL midop_reset got flags %b root %0d rem %0d expected 100 0 0", {bus_f.in_ready, bus_f.out_valid, bus_f.busy}, bus_f.root_out, bus_f.rem_out);
      end
      for (int i = 0; i < 30; i++) begin
         @(posedge clock); #1;
         if (bus_f.out_valid || bus_r.out_valid) stale++;
      end
      nvec++;
      if (stale != 0) begin
         nerr++; $display("FAIL midop_stale got %0d valid cycles expected 0", stale);
      end
   endtask

   task automatic test_sweep16();
      logic [15:0]     x;
      longint unsigned rt, xe;
      int              lat [4];
      for (int t = 0; t < 40; t++) begin
         x = (t == 0) ? 16'h0000 : (t == 1) ? 16'hFFFF : (t == 2) ? 16'hFFFE : 16'($urandom_range(0, 65535));
         xe = longint'(x);
         iv16 = 1'b1; num16 = x;
         @(posedge clock); #1;
         iv16 = 1'b0; num16 = 'x;
         for (int g = 0; g < 4; g++) lat[g] = -1;
         for (int c = 1; c <= 12; c++) begin
            @(posedge clock); #1;
            for (int g = 0; g < 4; g++)
               if (ov16[g] && lat[g] < 0) lat[g] = c;
         end
         for (int g = 0; g < 4; g++) begin
            rt = longint'(root16[g]);
            nvec++;
            if (lat[g] != (8 >> g)) begin
               nerr++; $display("FAIL sweep_latency k=%0d got %0d expected %0d", 1 << g, lat[g], 8 >> g);
            end
            nvec++;
            if (rt != isqrt(xe) || !(rt * rt <= xe && xe < (rt + 1) * (rt + 1))) begin
               nerr++; $display("FAIL sweep_root k=%0d x=%0d got %0d expected %0d", 1 << g, x, rt, isqrt(xe));
            end
            nvec++;
            if (longint'(rem16[g]) != xe - rt * rt) begin
               nerr++; $display("FAIL sweep_rem k=%0d x=%0d got %0d expected %0d", 1 << g, x, rem16[g], xe - rt * rt);
            end
         end
         ordy16 = 1'b1;
         @(posedge clock); #1;
         ordy16 = 1'b0;
         nvec++;
         if ({ov16, ir16} !== 8'h0F) begin
            nerr++; $display("FAIL sweep_drain got %h expected 0f", {ov16, ir16});
         end
      end
   endtask

   task automatic test_back_to_back();
      longint unsigned exp_q[$];
      longint unsigned xe;
      int got = 0, last_t = -1, cyc = 0, wait_c = 0;
      logic in_x;
      ordy32 = 1'b1; iv32 = 1'b1; num32 = $urandom;
      while (got < 6 && cyc < 400) begin
         if (bus_f.out_valid) begin
            nvec++;
            if (exp_q.size() == 0) begin
               nerr++; $display("FAIL b2b_unexpected got root %0d expected no result", bus_f.root_out);
            end else begin
               xe = exp_q.pop_front();
               if (longint'(bus_f.root_out) != isqrt(xe) || longint'(bus_f.rem_out) != xe - isqrt(xe) * isqrt(xe)
                   || longint'(bus_r.root_out) != rnd_root(xe, 16)) begin
                  nerr++; $display("FAIL b2b_result x=%0d got %0d/%0d/%0d expected %0d/%0d/%0d", xe, bus_f.root_out, bus_f.rem_out, bus_r.root_out, isqrt(xe), xe - isqrt(xe) * isqrt(xe), rnd_root(xe, 16));
               end
            end
            if (last_t >= 0) begin
               nvec++;
               if (cyc - last_t != 17) begin
                  nerr++; $display("FAIL b2b_interval got %0d expected 17", cyc - last_t);
               end
            end
            last_t = cyc;
            got++;
         end
         in_x = iv32 && bus_f.in_ready;
         if (in_x) exp_q.push_back(longint'(num32));
         @(posedge clock); #1;
         cyc++;
         if (in_x) num32 = $urandom;
      end
      iv32 = 1'b0;
      nvec++;
      if (got != 6) begin
         nerr++; $display("FAIL b2b_count got %0d expected 6", got);
      end
      while ((bus_f.busy || bus_f.out_valid) && wait_c < 40) begin
         @(posedge clock); #1;
         wait_c++;
      end
      ordy32 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic32();
      test_max32();
      test_round32();
      test_backpressure();
      test_reset_midop();
      test_sweep16();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
